// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcodes, control field layout and
// the per-opcode control words driven into ID/EX.
package id_pkg;

   localparam int EX_W = 4;
   localparam int M_W  = 2;
   localparam int WB_W = 2;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam int EX_REG_DST    = 3;
   localparam int EX_ALU_SRC    = 2;
   localparam int M_MEM_READ    = 1;
   localparam int M_MEM_WRITE   = 0;
   localparam int WB_REG_WRITE  = 1;
   localparam int WB_MEM_TO_REG = 0;

   typedef struct packed {
      logic [EX_W-1:0] ex;
      logic [M_W-1:0]  m;
      logic [WB_W-1:0] wb;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '{ex: 4'b0000, m: 2'b00, wb: 2'b00};
   localparam ctrl_t CTRL_R    = '{ex: 4'b1010, m: 2'b00, wb: 2'b10};
   localparam ctrl_t CTRL_LW   = '{ex: 4'b0100, m: 2'b10, wb: 2'b11};
   localparam ctrl_t CTRL_SW   = '{ex: 4'b0100, m: 2'b01, wb: 2'b00};
   localparam ctrl_t CTRL_ADDI = '{ex: 4'b0100, m: 2'b00, wb: 2'b10};
   localparam ctrl_t CTRL_BEQ  = '{ex: 4'b0001, m: 2'b00, wb: 2'b00};

   function automatic ctrl_t decode_ctrl(input logic [5:0] op);
      ctrl_t c;
      case (op)
         OP_R:    c = CTRL_R;
         OP_LW:   c = CTRL_LW;
         OP_SW:   c = CTRL_SW;
         OP_ADDI: c = CTRL_ADDI;
         OP_BEQ:  c = CTRL_BEQ;
         default: c = CTRL_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational hazard detection for the ID stage: load-use and beq operand
// hazards, plus EX/MEM-to-comparator forwarding when ID_BRANCH_FORWARD_EN is defined.
module id_hazard_unit
   import id_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             uses_rs,
   input  logic             uses_rt,
   input  logic             is_beq,
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rt,
   input  logic [REG_W-1:0] ex_dst_reg,
   input  logic             ex_mem_read,
   input  logic             ex_reg_write,
   input  logic [REG_W-1:0] mem_dst_reg,
   input  logic             mem_reg_write,
   input  logic             mem_mem_read,
   output logic             stall,
   output logic             fwd_a,
   output logic             fwd_b
);

   logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
   logic load_use, ex_br_hazard, mem_br_hazard;

   // $0 is hard-wired, so it never creates a dependency
   assign ex_rs_hit  = uses_rs && (rs != '0) && (rs == ex_dst_reg);
   assign ex_rt_hit  = uses_rt && (rt != '0) && (rt == ex_dst_reg);
   assign mem_rs_hit = uses_rs && (rs != '0) && (rs == mem_dst_reg);
   assign mem_rt_hit = uses_rt && (rt != '0) && (rt == mem_dst_reg);

   assign load_use     = ex_mem_read & (ex_rs_hit | ex_rt_hit);
   assign ex_br_hazard = is_beq & ex_reg_write & (ex_rs_hit | ex_rt_hit);

`ifdef ID_BRANCH_FORWARD_EN
   assign mem_br_hazard = is_beq & mem_reg_write & mem_mem_read & (mem_rs_hit | mem_rt_hit);
   assign fwd_a         = is_beq & mem_reg_write & ~mem_mem_read & mem_rs_hit;
   assign fwd_b         = is_beq & mem_reg_write & ~mem_mem_read & mem_rt_hit;
`else
   logic unused_mem_read;
   assign unused_mem_read = mem_mem_read;
   assign mem_br_hazard   = is_beq & mem_reg_write & (mem_rs_hit | mem_rt_hit);
   assign fwd_a           = 1'b0;
   assign fwd_b           = 1'b0;
`endif

   assign stall = load_use | ex_br_hazard | mem_br_hazard;

endmodule

// File: rtl/id_stage_pipelined.sv
// MIPS instruction-decode stage: decode, beq/j resolution, hazard bubbles and
// the ID/EX register. Optional macro ID_BRANCH_FORWARD_EN enables EX/MEM branch forwarding.
module id_stage_pipelined
   import id_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int PC_W        = 10,
   parameter int REG_W       = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [31:0]            instruc,
   input  logic                   instr_valid,
   input  logic [PC_W-1:0]        current_PC,
   output logic [REG_W-1:0]       ra,
   output logic [REG_W-1:0]       rb,
   input  logic [DATA_W-1:0]      bus_a_in,
   input  logic [DATA_W-1:0]      bus_b_in,
   input  logic [REG_W-1:0]       mem_dst_reg,
   input  logic                   mem_reg_write,
   input  logic                   mem_mem_read,
   input  logic [DATA_W-1:0]      mem_result,
   output logic                   pc_write,
   output logic                   ifid_write,
   output logic                   if_flush,
   output logic                   pc_sel,
   output logic [PC_W-1:0]        target_address,
   output logic [EX_W-1:0]        ex_EX_control,
   output logic [M_W-1:0]         ex_M_control,
   output logic [WB_W-1:0]        ex_WB_control,
   output logic [DATA_W-1:0]      ex_bus_a,
   output logic [DATA_W-1:0]      ex_bus_b,
   output logic [DATA_W-1:0]      ex_immed,
   output logic [REG_W-1:0]       ex_dst_reg,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

   logic [5:0]        opcode;
   logic [REG_W-1:0]  rd, dst_reg;
   ctrl_t             ctrl;
   logic              is_beq, is_j, uses_rs, uses_rt;
   logic              stall_raw, stall, fwd_a, fwd_b, taken;
   logic [DATA_W-1:0] a_cmp, b_cmp, immed_ext;

   assign opcode = instruc[31:26];
   assign ra     = instruc[25:21];
   assign rb     = instruc[20:16];
   assign rd     = instruc[15:11];

   always_comb begin
      ctrl = CTRL_NONE;
      if (instr_valid) ctrl = decode_ctrl(opcode);
   end

   assign is_beq  = instr_valid && (opcode == OP_BEQ);
   assign is_j    = instr_valid && (opcode == OP_J);
   assign uses_rs = instr_valid && (opcode inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ});
   assign uses_rt = instr_valid && (opcode inside {OP_R, OP_SW, OP_BEQ});

   id_hazard_unit #(.REG_W(REG_W)) u_hazard (
      .uses_rs       (uses_rs),
      .uses_rt       (uses_rt),
      .is_beq        (is_beq),
      .rs            (ra),
      .rt            (rb),
      .ex_dst_reg    (ex_dst_reg),
      .ex_mem_read   (ex_M_control[M_MEM_READ]),
      .ex_reg_write  (ex_WB_control[WB_REG_WRITE]),
      .mem_dst_reg   (mem_dst_reg),
      .mem_reg_write (mem_reg_write),
      .mem_mem_read  (mem_mem_read),
      .stall         (stall_raw),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b)
   );

   // Reset overrides any stall/redirect so fetch is free the moment reset asserts
   assign stall = stall_raw & reset;

   assign a_cmp = fwd_a ? mem_result : bus_a_in;
   assign b_cmp = fwd_b ? mem_result : bus_b_in;
   assign taken = reset & ~stall & (is_j | (is_beq & (a_cmp == b_cmp)));

   assign pc_write       = ~stall;
   assign ifid_write     = ~stall;
   assign pc_sel         = taken;
   assign if_flush       = taken;
   assign target_address = is_j ? instruc[PC_W-1:0] : current_PC + instruc[PC_W-1:0];

   assign dst_reg   = ctrl.ex[EX_REG_DST] ? rd : rb;
   assign immed_ext = {{(DATA_W-16){instruc[15]}}, instruc[15:0]};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_EX_control <= '0;
         ex_M_control  <= '0;
         ex_WB_control <= '0;
         ex_bus_a      <= '0;
         ex_bus_b      <= '0;
         ex_immed      <= '0;
         ex_dst_reg    <= '0;
         stall_count   <= '0;
      end else begin
         ex_EX_control <= stall ? '0 : ctrl.ex;
         ex_M_control  <= stall ? '0 : ctrl.m;
         ex_WB_control <= stall ? '0 : ctrl.wb;
         ex_bus_a      <= bus_a_in;
         ex_bus_b      <= bus_b_in;
         ex_immed      <= immed_ext;
         ex_dst_reg    <= dst_reg;
         if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Self-checking bench for id_stage_pipelined: vector table plus hand-written
// hazard/reset sequences, ID/EX results checked through a scoreboard queue.
module tb_id_stage_pipelined;

   localparam int DATA_W = 32;
   localparam int PC_W   = 10;
   localparam int REG_W  = 5;
   localparam int SCW    = 16;

   localparam logic [7:0] C_R    = 8'b1010_00_10;
   localparam logic [7:0] C_LW   = 8'b0100_10_11;
   localparam logic [7:0] C_SW   = 8'b0100_01_00;
   localparam logic [7:0] C_ADDI = 8'b0100_00_10;
   localparam logic [7:0] C_BEQ  = 8'b0001_00_00;
   localparam logic [7:0] C_NONE = 8'b0000_00_00;

   localparam logic [5:0] O_LW = 6'b100011, O_SW = 6'b101011, O_ADDI = 6'b001000, O_BEQ = 6'b000100;

   logic              clock = 1'b0;
   logic              reset;
   logic [31:0]       instruc;
   logic              instr_valid;
   logic [PC_W-1:0]   current_PC;
   logic [REG_W-1:0]  ra, rb;
   logic [DATA_W-1:0] bus_a_in, bus_b_in;
   logic [REG_W-1:0]  mem_dst_reg;
   logic              mem_reg_write, mem_mem_read;
   logic [DATA_W-1:0] mem_result;
   logic              pc_write, ifid_write, if_flush, pc_sel;
   logic [PC_W-1:0]   target_address;
   logic [3:0]        ex_EX_control;
   logic [1:0]        ex_M_control, ex_WB_control;
   logic [DATA_W-1:0] ex_bus_a, ex_bus_b, ex_immed;
   logic [REG_W-1:0]  ex_dst_reg;
   logic [SCW-1:0]    stall_count;

   id_stage_pipelined #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W), .STALL_CNT_W(SCW)) dut (
      .clock(clock), .reset(reset), .instruc(instruc), .instr_valid(instr_valid),
      .current_PC(current_PC), .ra(ra), .rb(rb), .bus_a_in(bus_a_in), .bus_b_in(bus_b_in),
      .mem_dst_reg(mem_dst_reg), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_result(mem_result), .pc_write(pc_write), .ifid_write(ifid_write),
      .if_flush(if_flush), .pc_sel(pc_sel), .target_address(target_address),
      .ex_EX_control(ex_EX_control), .ex_M_control(ex_M_control), .ex_WB_control(ex_WB_control),
      .ex_bus_a(ex_bus_a), .ex_bus_b(ex_bus_b), .ex_immed(ex_immed),
      .ex_dst_reg(ex_dst_reg), .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      string           name;
      logic [31:0]     instr;
      logic            valid;
      logic [PC_W-1:0] pc;
      logic [31:0]     bus_a, bus_b;
      logic [4:0]      mem_dst;
      logic            mem_rw, mem_mr;
      logic [31:0]     mem_res;
      logic            exp_stall, exp_take;
      logic [PC_W-1:0] exp_tgt;
      logic [7:0]      exp_ctrl;
      logic [4:0]      exp_dst;
   } vec_t;

   typedef struct {
      string       name;
      logic [7:0]  ctrl;
      logic [31:0] a, b, imm;
      logic [4:0]  dst;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   vec_t        tbl[13];
   int          checks = 0;
   int          failures = 0;
   logic [15:0] model_cnt = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd);
      return {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic vec_t mk(input string n, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                               input logic [31:0] a, b, input logic st, tk,
                               input logic [PC_W-1:0] tg, input logic [7:0] c, input logic [4:0] d);
      vec_t v;
      v.name = n; v.instr = ins; v.valid = 1'b1; v.pc = pc; v.bus_a = a; v.bus_b = b;
      v.mem_dst = '0; v.mem_rw = 1'b0; v.mem_mr = 1'b0; v.mem_res = '0;
      v.exp_stall = st; v.exp_take = tk; v.exp_tgt = tg; v.exp_ctrl = c; v.exp_dst = d;
      return v;
   endfunction

   // Called just after a rising edge: drive, check the combinational side, then the ID/EX result
   task automatic apply(input vec_t v);
      exp_t e;
      exp_t got;
      instruc = v.instr; instr_valid = v.valid; current_PC = v.pc;
      bus_a_in = v.bus_a; bus_b_in = v.bus_b;
      mem_dst_reg = v.mem_dst; mem_reg_write = v.mem_rw; mem_mem_read = v.mem_mr; mem_result = v.mem_res;
      #3;
      chk({v.name, ".pc_write"}, pc_write, !v.exp_stall);
      chk({v.name, ".ifid_write"}, ifid_write, !v.exp_stall);
      chk({v.name, ".pc_sel"}, pc_sel, v.exp_take);
      chk({v.name, ".if_flush"}, if_flush, v.exp_take);
      if (v.exp_take) chk({v.name, ".target"}, target_address, v.exp_tgt);
      chk({v.name, ".ra_rb"}, {ra, rb}, {v.instr[25:21], v.instr[20:16]});
      if (v.exp_stall && model_cnt != 16'hFFFF) model_cnt++;
      e.name = v.name;
      e.ctrl = v.exp_stall ? C_NONE : v.exp_ctrl;
      e.a = v.bus_a; e.b = v.bus_b;
      e.imm = {{16{v.instr[15]}}, v.instr[15:0]};
      e.dst = v.exp_dst; e.cnt = model_cnt;
      sb.push_back(e);
      @(posedge clock); #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         got = sb.pop_front();
         chk({got.name, ".ex_ctrl"}, {ex_EX_control, ex_M_control, ex_WB_control}, got.ctrl);
         chk({got.name, ".ex_bus"}, {ex_bus_a, ex_bus_b}, {got.a, got.b});
         chk({got.name, ".ex_immed"}, ex_immed, got.imm);
         chk({got.name, ".ex_dst"}, ex_dst_reg, got.dst);
         chk({got.name, ".stall_count"}, stall_count, got.cnt);
      end
   endtask

   // add $5 then beq $5,$0,+2; the EX/MEM copy of the add carries result r
   task automatic branch_seq(input logic [31:0] r);
      vec_t v;
      logic tk;
      tk = (r == 0);
      apply(mk("seq_add", enc_r(5'd1, 5'd2, 5'd5), 10'd39, 32'd3, 32'd4, 1'b0, 1'b0, '0, C_R, 5'd5));
      apply(mk("seq_beq1", enc_i(O_BEQ, 5'd5, 5'd0, 16'd2), 10'd40, 32'd99, 32'd0, 1'b1, 1'b0, '0, C_BEQ, 5'd0));
`ifdef ID_BRANCH_FORWARD_EN
      v = mk("seq_beq2_fwd", enc_i(O_BEQ, 5'd5, 5'd0, 16'd2), 10'd40, 32'd99, 32'd0, 1'b0, tk, 10'd42, C_BEQ, 5'd0);
      v.mem_dst = 5'd5; v.mem_rw = 1'b1; v.mem_res = r;
      apply(v);
`else
      v = mk("seq_beq2", enc_i(O_BEQ, 5'd5, 5'd0, 16'd2), 10'd40, 32'd99, 32'd0, 1'b1, 1'b0, '0, C_BEQ, 5'd0);
      v.mem_dst = 5'd5; v.mem_rw = 1'b1; v.mem_res = r;
      apply(v);
      apply(mk("seq_beq3", enc_i(O_BEQ, 5'd5, 5'd0, 16'd2), 10'd40, r, 32'd0, 1'b0, tk, 10'd42, C_BEQ, 5'd0));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk("lw",       enc_i(O_LW, 5'd1, 5'd2, 16'd4),        10'd1,    32'd100, 32'd200, 1'b0, 1'b0, '0,     C_LW,   5'd2);
      tbl[1]  = mk("add_stall", enc_r(5'd2, 5'd4, 5'd3),              10'd2,    32'd11,  32'd22,  1'b1, 1'b0, '0,     C_R,    5'd3);
      tbl[2]  = mk("add_go",   enc_r(5'd2, 5'd4, 5'd3),               10'd2,    32'd11,  32'd22,  1'b0, 1'b0, '0,     C_R,    5'd3);
      tbl[3]  = mk("lw_r0",    enc_i(O_LW, 5'd1, 5'd0, 16'd8),        10'd3,    32'd5,   32'd6,   1'b0, 1'b0, '0,     C_LW,   5'd0);
      tbl[4]  = mk("add_r0",   enc_r(5'd0, 5'd0, 5'd6),               10'd4,    32'd0,   32'd0,   1'b0, 1'b0, '0,     C_R,    5'd6);
      tbl[5]  = mk("beq_pc20", enc_i(O_BEQ, 5'd1, 5'd1, 16'd5),       10'd20,   32'd9,   32'd9,   1'b0, 1'b1, 10'd25, C_BEQ,  5'd1);
      tbl[6]  = mk("beq_wrap", enc_i(O_BEQ, 5'd1, 5'd1, 16'd5),       10'd1020, 32'd9,   32'd9,   1'b0, 1'b1, 10'd1,  C_BEQ,  5'd1);
      tbl[7]  = mk("beq_nt",   enc_i(O_BEQ, 5'd1, 5'd2, 16'd3),       10'd30,   32'd5,   32'd6,   1'b0, 1'b0, '0,     C_BEQ,  5'd2);
      tbl[8]  = mk("j_3ff",    {6'b000010, 26'h00003FF},              10'd31,   32'd1,   32'd2,   1'b0, 1'b1, 10'd1023, C_NONE, 5'd0);
      tbl[9]  = mk("op_3f",    {6'b111111, 5'd2, 5'd7, 16'h1234},     10'd32,   32'd7,   32'd8,   1'b0, 1'b0, '0,     C_NONE, 5'd7);
      tbl[10] = mk("sw",       enc_i(O_SW, 5'd3, 5'd7, 16'd8),        10'd33,   32'd70,  32'd71,  1'b0, 1'b0, '0,     C_SW,   5'd7);
      tbl[11] = mk("addi_neg", enc_i(O_ADDI, 5'd1, 5'd8, 16'hFFFF),   10'd34,   32'd12,  32'd13,  1'b0, 1'b0, '0,     C_ADDI, 5'd8);
      tbl[12] = mk("invalid",  enc_r(5'd8, 5'd8, 5'd9),               10'd35,   32'd14,  32'd15,  1'b0, 1'b0, '0,     C_NONE, 5'd8);
      tbl[12].valid = 1'b0;

      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         instruc = (i == 0) ? {6'b000010, 26'h0000155} : $urandom;
         instr_valid = 1'b1; current_PC = PC_W'($urandom);
         bus_a_in = $urandom; bus_b_in = $urandom;
         mem_dst_reg = REG_W'($urandom); mem_reg_write = 1'($urandom); mem_mem_read = 1'($urandom);
         mem_result = $urandom;
         @(posedge clock); #4;
         chk("rst.ex_ctrl", {ex_EX_control, ex_M_control, ex_WB_control}, 8'h00);
         chk("rst.ex_data", {ex_bus_a, ex_bus_b, ex_immed, ex_dst_reg}, '0);
         chk("rst.stall_count", stall_count, 16'd0);
         chk("rst.fetch", {pc_write, ifid_write, pc_sel, if_flush}, 4'b1100);
      end
      @(posedge clock); #1;
      reset = 1'b1;

      for (int i = 0; i < 13; i++) apply(tbl[i]);

      branch_seq(32'd0);
      branch_seq(32'd7);

      // Reset asserted in the middle of a load-use stall
      apply(mk("pre_lw", enc_i(O_LW, 5'd1, 5'd2, 16'd4), 10'd50, 32'd1, 32'd2, 1'b0, 1'b0, '0, C_LW, 5'd2));
      instruc = enc_r(5'd2, 5'd4, 5'd3); instr_valid = 1'b1;
      #2;
      chk("midrst.pre_stall", pc_write, 1'b0);
      reset = 1'b0;
      #1;
      chk("midrst.fetch", {pc_write, ifid_write, pc_sel, if_flush}, 4'b1100);
      chk("midrst.ex_ctrl", {ex_EX_control, ex_M_control, ex_WB_control}, 8'h00);
      chk("midrst.ex_dst", ex_dst_reg, 5'd0);
      chk("midrst.stall_count", stall_count, 16'd0);
      @(posedge clock); #1;
      chk("midrst.hold", {ex_EX_control, ex_M_control, ex_WB_control, ex_bus_a}, '0);
      reset = 1'b1;
      model_cnt = '0;
      sb.delete();
      apply(mk("post_rst_add", enc_r(5'd2, 5'd4, 5'd3), 10'd51, 32'd5, 32'd6, 1'b0, 1'b0, '0, C_R, 5'd3));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Next-generation instruction-decode stage for the 5-stage MIPS core, parametrised in data, PC and control widths.
- Decodes the IF/ID instruction, resolves beq/j in ID, detects load-use and branch-operand hazards, inserts bubbles, and owns the ID/EX pipeline register.
- The register bank stays external: rs/rt addresses go out, bus values come back combinationally.
- Feeds the EX stage directly, and drives pc_write, ifid_write and if_flush back to fetch.

Parameters:
DATA_W, 32, datapath width
PC_W, 10, instruction-address width
REG_W, 5, register-address width
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
instruc  in  32  IF/ID instruction
instr_valid  in  1  IF/ID holds a real instruction
current_PC  in  PC_W  PC+1 of IF/ID instruction
ra, rb  out  REG_W  register-bank read addresses (instruc[25:21], [20:16])
bus_a_in, bus_b_in  in  DATA_W  register-bank read data
mem_dst_reg  in  REG_W  EX/MEM destination register
mem_reg_write  in  1  EX/MEM writes a register
mem_mem_read  in  1  EX/MEM is a load
mem_result  in  DATA_W  EX/MEM ALU result (forwarding only)
pc_write, ifid_write  out  1  0 = hold fetch/IF/ID
if_flush  out  1  squash IF/ID next edge
pc_sel  out  1  take target_address
target_address  out  PC_W  branch or jump target
ex_EX_control  out  4  {reg_dst, alu_src, alu_op[1:0]}
ex_M_control  out  2  {mem_read, mem_write}
ex_WB_control  out  2  {reg_write, mem_to_reg}
ex_bus_a, ex_bus_b, ex_immed  out  DATA_W  registered operands, sign-extended immediate
ex_dst_reg  out  REG_W  registered destination
stall_count  out  STALL_CNT_W  stall cycles since reset

Behaviour:
- Decode, opcode -> {EX, M, WB}:
  - 000000 R: 1010/00/10
  - 100011 lw: 0100/10/11
  - 101011 sw: x100/01/00 (x driven 0)
  - 001000 addi: 0100/00/10
  - 000100 beq: 0001/00/00
  - 000010 j: none
  - other opcode or instr_valid=0: all control 0
- Destination register = rd if reg_dst, else rt.
- Source registers:
  - uses_rs: all except j.
  - uses_rt: R, sw, beq.
  - Register 0 never matches in any hazard comparison.
- load_use: ID/EX M.mem_read=1 and ex_dst_reg matches a used source.
- br_hazard (beq only):
  - ID/EX WB.reg_write=1 and ex_dst_reg matches rs/rt, or
  - EX/MEM mem_reg_write=1 and mem_dst_reg matches rs/rt.
- stall = load_use | br_hazard.
  - stall -> pc_write=0, ifid_write=0, and the ID/EX control fields load 0 (bubble). Operand fields still load.
  - Stall repeats each cycle until cleared: lw then beq = 2 stalls; ALU op then beq = 2 stalls.
- Branch/jump, evaluated only when stall=0:
  - beq: taken when bus_a==bus_b -> pc_sel=1, if_flush=1, target = current_PC + immed[PC_W-1:0], mod 2^PC_W.
  - j: pc_sel=1, if_flush=1, target = instruc[PC_W-1:0].
  - Otherwise pc_sel=0 and if_flush=0.
  - Branch/jump have zero added latency: the target is presented in the same cycle as decode.
- ID/EX register: one-cycle latency, updated every edge. No hold input; EX never stalls.
- stall_count: +1 per stall cycle, saturates at all-ones.
- Reset (async assert, clock-synchronous release): all ex_* = 0, stall_count = 0.
  - Combinational outputs follow inputs; during reset, pc_write/ifid_write are forced 1 and pc_sel/if_flush forced 0.
  - A reset asserted mid-stall aborts the stall immediately.

Optional Feature:
- ID_BRANCH_FORWARD_EN defined:
  - EX/MEM result is forwarded into the branch comparator when mem_reg_write=1, mem_mem_read=0 and the registers match.
  - br_hazard from EX/MEM is raised only if mem_mem_read=1.
  - ALU op then beq = 1 stall.
- Undefined: mem_result is ignored (port kept); behaviour as above.

Decomposition:
- Package id_pkg: opcode constants; control field widths and bit positions; per-opcode control words.
- One natural sub-module, id_hazard_unit: purely combinational; computes stall and the forwarding selects.

Test Plan:
- Reset: hold reset=0 with random inputs -> all ex_* 0, stall_count 0, pc_write 1, pc_sel 0.
- lw $2 then add $3,$2,$4 -> one cycle pc_write=0 with a bubble in ID/EX, then add decodes with ex_EX_control=1010; stall_count=1.
- beq $1,$1,+5 at current_PC=20 -> pc_sel=1, target_address=25, if_flush=1. Same at PC=1020 with PC_W=10 -> target wraps to 1.
- add $5 then beq $5,$0: 2 stall cycles without the macro, 1 with ID_BRANCH_FORWARD_EN. Verify the branch outcome with mem_result=0 and with mem_result=7.
- j 0x3FF -> pc_sel=1, target_address=1023; opcode 111111 -> all control 0, no stall.
- Hazard on $0 (lw $0 then add using $0) -> no stall.
